// File: rtl/shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier
//   Sequential unsigned WIDTH x WIDTH -> 2*WIDTH multiplier, radix-2
//   shift-and-add. A single WIDTH-bit full-adder ripple chain is reused once
//   per iteration. Operands are taken over a valid/ready input handshake and
//   the product is offered over a valid/ready output handshake.
//
//   Optional feature macro: EARLY_TERM_EN
//     When defined, RUN stops as soon as the remaining multiplier bits are all
//     zero and the accumulator is aligned with a one-step right shift.
//     When undefined, RUN always takes exactly WIDTH cycles.
//
// Ports
//   clk        in   1        clock, all state updates on posedge
//   rst        in   1        synchronous active-high reset
//   in_valid   in   1        operand pair a/b valid
//   in_ready   out  1        operands accepted (high only in IDLE)
//   a          in   WIDTH    multiplicand, unsigned
//   b          in   WIDTH    multiplier, unsigned
//   out_valid  out  1        product valid (high only in DONE)
//   out_ready  in   1        consumer accepts product
//   product    out  2*WIDTH  a*b, held stable while out_valid=1
//   busy       out  1        high while iterating (RUN)
// -----------------------------------------------------------------------------
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q,   state_d;
  logic [WIDTH-1:0]     mcand_q,   mcand_d;
  logic [WIDTH-1:0]     acc_hi_q,  acc_hi_d;
  logic [WIDTH-1:0]     acc_lo_q,  acc_lo_d;
  logic [CW-1:0]        count_q,   count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  // ---------------------------------------------------------------------------
  // Shared ripple-carry adder: acc_hi + (acc_lo[0] ? mcand : 0), carry-in 0.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH:0]     carry;
  logic [2*WIDTH-1:0] shifted;

  assign addend   = acc_lo_q[0] ? mcand_q : '0;
  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign sum[gi]     = acc_hi_q[gi] ^ addend[gi] ^ carry[gi];
      assign carry[gi+1] = (acc_hi_q[gi] & addend[gi]) |
                           (carry[gi] & (acc_hi_q[gi] ^ addend[gi]));
    end
  endgenerate

  // Carry becomes the new top bit, so nothing is lost on the right shift.
  assign shifted = {carry[WIDTH], sum, acc_lo_q[WIDTH-1:1]};

  // ---------------------------------------------------------------------------
  // Finish condition and final product value
  // ---------------------------------------------------------------------------
  logic               finish;
  logic [2*WIDTH-1:0] done_val;

`ifdef EARLY_TERM_EN
  // acc_lo[1 .. WIDTH-1-count] still hold unprocessed multiplier bits.
  // If they are all zero, the remaining iterations would only shift, so the
  // accumulator is shifted by the outstanding count in one go.
  logic          rem_zero;
  logic [CW-1:0] shamt;

  always_comb begin
    rem_zero = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      if ((i + int'(count_q)) < WIDTH && acc_lo_q[i]) begin
        rem_zero = 1'b0;
      end
    end
  end

  assign shamt    = LAST - count_q;
  assign finish   = rem_zero;
  assign done_val = shifted >> shamt;
`else
  assign finish   = (count_q == LAST);
  assign done_val = shifted;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d  = a;
          acc_hi_d = '0;
          acc_lo_d = b;
          count_d  = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        {acc_hi_d, acc_lo_d} = shifted;
        count_d              = count_q + 1'b1;
        if (finish) begin
          product_d = done_val;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        // product_q is intentionally left untouched on the handshake.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q == S_RUN);
    product   = product_q;
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// tb_shift_add_multiplier
//   Directed bench for shift_add_multiplier (WIDTH=4). Stimulus pushes the
//   expected product into a queue on every accepted operand pair; a monitor
//   pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_shift_add_multiplier;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int             errors = 0;
  int             checks = 0;
  logic [2*W-1:0] exp_q[$];
  int             n_push = 0;
  int             n_pop  = 0;
  bit             rand_mode   = 1'b0;
  logic           ready_force = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // RUN edges expected for a given multiplier value.
  function automatic int exp_edges(input logic [W-1:0] bb);
    int m;
    m = W;
`ifdef EARLY_TERM_EN
    m = 1;
    for (int i = 0; i < W; i++) begin
      if (bb[i]) m = i + 1;
    end
`else
    if (bb === 'x) m = 0;
`endif
    return m;
  endfunction

  // out_ready driver: fixed level or random stalls, changes well away from edges.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Monitor / scoreboard.
  logic           prev_ov = 1'b0;
  logic           prev_hs = 1'b0;
  logic [2*W-1:0] prev_prod = '0;

  always @(negedge clk) begin
    logic [2*W-1:0] e;
    if (rst) begin
      exp_q.delete();
      prev_ov = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_ov && !prev_hs && out_valid) check("product_hold", product, prev_prod);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: product=%h with nothing outstanding", product);
        end else begin
          e = exp_q.pop_front();
          n_pop++;
          $display("txn %0d: product=%h expected=%h", n_pop, product, e);
          check("product", product, e);
        end
      end
      prev_ov   = out_valid;
      prev_prod = product;
      prev_hs   = out_valid && out_ready;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_reached", in_ready, 1);
  endtask

  // Issue one operand pair and wait until the product is presented.
  task automatic do_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input bit chk);
    int n;
    bit ir_ok;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
      return;
    end
    in_valid = 1'b1;
    a = aa;
    b = bb;
    @(posedge clk);
    exp_q.push_back((2*W)'(aa) * (2*W)'(bb));
    n_push++;
    #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    n = 0;
    ir_ok = 1'b1;
    while (!out_valid && n < 50) begin
      if (in_ready) ir_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    if (chk) begin
      check("latency", n, exp_edges(bb));
      check("in_ready_low_run", ir_ok, 1);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 0);
    rst = 1'b0;

    // 1: max operands, out_ready high before DONE
    ready_force = 1'b1;
    do_op(4'd15, 4'd15, 1'b1);
    wait_idle();

    // 2: zero operands
    do_op(4'd9, 4'd0, 1'b1);
    wait_idle();
    do_op(4'd0, 4'd13, 1'b1);
    wait_idle();

    // 3: consumer stall, in_valid held high during DONE
    ready_force = 1'b0;
    do_op(4'd7, 4'd6, 1'b1);
    in_valid = 1'b1;
    a = 4'd1;
    b = 4'd1;
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_product", product, 8'h2A);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("stall_not_accepted", busy, 0);
    ready_force = 1'b1;
    wait_idle();
    check("post_hs_out_valid", out_valid, 0);
    check("post_hs_product_kept", product, 8'h2A);

    // 4: reset during RUN discards the operation
    in_valid = 1'b1;
    a = 4'd5;
    b = 4'd11;
    @(posedge clk);
    exp_q.push_back(8'd55);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_product", product, 0);
    do_op(4'd3, 4'd4, 1'b1);
    wait_idle();

    // 5: short multipliers (early termination when enabled)
    do_op(4'd12, 4'd1, 1'b1);
    wait_idle();
    do_op(4'd12, 4'd4, 1'b1);
    wait_idle();

    // 6: every operand pair with random consumer stalls
    rand_mode = 1'b1;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        do_op(W'(ai), W'(bi), 1'b0);
      end
    end
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    rand_mode = 1'b0;
    check("drain_empty", exp_q.size(), 0);
    check("result_count", n_pop, n_push);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
